// File: rtl/ifu_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pc_gen_pkg
// Purpose  : Shared widths, reset PC and fetch-queue entry layout for the
//            fetch-stage PC generator.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_pc_gen_pkg;

    // Instruction-bus address width, reused for every PC in the fetch stage
    localparam int INS_BUS_A = 32;

    // Default fetch PC after reset
    localparam logic [INS_BUS_A-1:0] DEF_RESET_PC = 32'h0000_0000;

    // One fetch-queue slot: PC and prediction captured at request time,
    // instruction and filled flag written when the response returns
    typedef struct packed {
        logic [INS_BUS_A-1:0] pc;
        logic                 taken;
        logic [31:0]          inst;
        logic                 filled;
    } ifu_entry_t;

    localparam int IFU_ENTRY_W = $bits(ifu_entry_t);

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_queue
// Purpose  : In-order fetch queue. Slots are allocated when a request is
//            granted, filled when its response returns and popped by decode.
//            Flush empties the queue and clears every filled flag.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_queue
    import ifu_pc_gen_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   n_rst_i,
    input  logic                   alloc_en,
    input  logic [INS_BUS_A-1:0]   alloc_pc,
    input  logic                   alloc_taken,
    input  logic                   fill_en,
    input  logic [31:0]            fill_inst,
    input  logic                   pop_en,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] outstanding,
    output ifu_entry_t             head_entry
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PW-1:0] r_alloc;
    logic [PW-1:0] r_fill;
    logic [PW-1:0] r_head;
    ifu_entry_t    r_mem [DEPTH];

    logic [IW-1:0] w_alloc_idx;
    logic [IW-1:0] w_fill_idx;
    logic [IW-1:0] w_head_idx;

    assign w_alloc_idx = r_alloc[IW-1:0];
    assign w_fill_idx  = r_fill[IW-1:0];
    assign w_head_idx  = r_head[IW-1:0];

    assign count       = r_alloc - r_head;
    assign outstanding = r_alloc - r_fill;
    assign head_entry  = r_mem[w_head_idx];

    // Pointer update: flush collapses fill/head onto alloc, otherwise each
    // pointer advances independently on its own event
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_alloc <= '0;
            r_fill  <= '0;
            r_head  <= '0;
        end else if (flush) begin
            r_fill <= r_alloc;
            r_head <= r_alloc;
        end else begin
            if (alloc_en) r_alloc <= r_alloc + 1'b1;
            if (fill_en)  r_fill  <= r_fill + 1'b1;
            if (pop_en)   r_head  <= r_head + 1'b1;
        end
    end

    // Entry storage: allocation and fill never target the same slot because
    // allocation stops when all DEPTH slots are in use
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].filled <= 1'b0;
            end
        end else begin
            if (alloc_en) begin
                r_mem[w_alloc_idx].pc     <= alloc_pc;
                r_mem[w_alloc_idx].taken  <= alloc_taken;
                r_mem[w_alloc_idx].inst   <= '0;
                r_mem[w_alloc_idx].filled <= 1'b0;
            end
            if (fill_en) begin
                r_mem[w_fill_idx].inst   <= fill_inst;
                r_mem[w_fill_idx].filled <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pc_gen
// Purpose  : Fetch-stage PC generator. Holds the fetch PC, issues in-order
//            instruction-memory requests, queues responses with their PC and
//            prediction, and hands them to decode. A redirect flushes the
//            queue and discards responses still in flight.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_pc_gen
    import ifu_pc_gen_pkg::*;
#(
    parameter logic [INS_BUS_A-1:0] RESET_PC   = DEF_RESET_PC,
    parameter int                   FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    output logic [INS_BUS_A-1:0] bp_pc_o,
    output logic                 bp_stall_o,
    input  logic [INS_BUS_A-1:0] bp_next_pc_i,
    input  logic                 bp_next_taken_i,
    input  logic                 redirect_i,
    input  logic [INS_BUS_A-1:0] redirect_pc_i,
    input  logic                 stall_i,
    output logic                 imem_req_o,
    output logic [INS_BUS_A-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [31:0]          imem_rdata_i,
    output logic                 id_valid_o,
    input  logic                 id_ready_i,
    output logic [INS_BUS_A-1:0] id_pc_o,
    output logic [31:0]          id_inst_o,
    output logic                 id_taken_o
);

    localparam int            PW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] C_DEPTH = PW'(FIFO_DEPTH);

    logic [INS_BUS_A-1:0] r_pc;
    logic [PW-1:0]        r_drop_cnt;

    logic [PW-1:0] w_count;
    logic [PW-1:0] w_outstanding;
    ifu_entry_t    w_head;
    logic          w_req;
    logic          w_fire;
    logic          w_rv_live;
    logic          w_rv_drop;
    logic          w_fill;
    logic          w_id_valid;
    logic          w_pop;

    // Requests are held off while a redirect is pending, while stalled, when
    // the queue is full and until every stale response has been drained.
    // Gating with n_rst_i keeps the request low while reset is asserted.
    assign w_req = n_rst_i && !redirect_i && !stall_i &&
                   (w_count < C_DEPTH) && (r_drop_cnt == '0);
    assign w_fire = w_req && imem_gnt_i;

    // A response either belongs to a live queue slot or is a stale one
    assign w_rv_live = imem_rvalid_i && (r_drop_cnt == '0);
    assign w_rv_drop = imem_rvalid_i && (r_drop_cnt != '0);
    assign w_fill    = w_rv_live && !redirect_i;

    assign w_id_valid = !redirect_i && (w_count != '0) && w_head.filled;
    assign w_pop      = w_id_valid && id_ready_i;

    assign bp_pc_o     = r_pc;
    assign imem_addr_o = r_pc;
    assign imem_req_o  = w_req;
    assign bp_stall_o  = !w_fire;

    assign id_valid_o = w_id_valid;
    assign id_pc_o    = w_head.pc;
    assign id_inst_o  = w_head.inst;
    assign id_taken_o = w_head.taken;

    // Fetch PC: redirect wins, otherwise follow the predictor on each grant
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_pc <= redirect_pc_i;
        end else if (w_fire) begin
            r_pc <= bp_next_pc_i;
        end
    end

    // Stale-response counter: on redirect it absorbs every response still in
    // flight (live outstanding plus any already being dropped), less the one
    // retiring this cycle; otherwise it counts down as stale data arrives
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_drop_cnt <= '0;
        end else if (redirect_i) begin
            r_drop_cnt <= w_outstanding - PW'(w_rv_live) + r_drop_cnt - PW'(w_rv_drop);
        end else if (w_rv_drop) begin
            r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    ifu_fetch_queue #(
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .n_rst_i     (n_rst_i),
        .alloc_en    (w_fire),
        .alloc_pc    (r_pc),
        .alloc_taken (bp_next_taken_i),
        .fill_en     (w_fill),
        .fill_inst   (imem_rdata_i),
        .pop_en      (w_pop),
        .flush       (redirect_i),
        .count       (w_count),
        .outstanding (w_outstanding),
        .head_entry  (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_pc_gen
// Purpose  : Directed, table-driven bench for ifu_pc_gen. Each record is one
//            clock cycle of stimulus with hand-computed expected outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_pc_gen;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] bp_pc;
    logic        bp_stall;
    logic [31:0] bp_next_pc;
    logic        bp_next_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_taken;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [31:0] npc;
        logic        ntk;
        logic        redir;
        logic [31:0] rpc;
        logic        stall;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_bst;
        logic        e_val;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_tk;
    } vec_t;

    vec_t tbl[$];

    ifu_pc_gen #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i           (clk),
        .n_rst_i         (n_rst),
        .bp_pc_o         (bp_pc),
        .bp_stall_o      (bp_stall),
        .bp_next_pc_i    (bp_next_pc),
        .bp_next_taken_i (bp_next_taken),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .stall_i         (stall),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_gnt_i      (imem_gnt),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .id_valid_o      (id_valid),
        .id_ready_i      (id_ready),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst),
        .id_taken_o      (id_taken)
    );

    always #5 clk = ~clk;

    // Instruction word returned for a given fetch address
    function automatic logic [31:0] d(input logic [31:0] pc);
        return 32'hC0DE_0000 | pc;
    endfunction

    function automatic vec_t mk(
        input logic rst, input logic gnt, input logic rv, input logic [31:0] rdata,
        input logic [31:0] npc, input logic ntk, input logic redir, input logic [31:0] rpc,
        input logic stl, input logic rdy,
        input logic e_req, input logic [31:0] e_addr, input logic e_bst, input logic e_val,
        input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_tk);
        vec_t v;
        v.rst = rst;     v.gnt = gnt;       v.rv = rv;       v.rdata = rdata;
        v.npc = npc;     v.ntk = ntk;       v.redir = redir; v.rpc = rpc;
        v.stall = stl;   v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_bst = e_bst; v.e_val = e_val;
        v.e_pc = e_pc;   v.e_inst = e_inst; v.e_tk = e_tk;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge, check just after
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        n_rst         = !v.rst;
        imem_gnt      = v.gnt;
        imem_rvalid   = v.rv;
        imem_rdata    = v.rdata;
        bp_next_pc    = v.npc;
        bp_next_taken = v.ntk;
        redirect      = v.redir;
        redirect_pc   = v.rpc;
        stall         = v.stall;
        id_ready      = v.rdy;
        #1;
        chk(idx, "imem_req",  32'(imem_req), 32'(v.e_req));
        chk(idx, "imem_addr", imem_addr,     v.e_addr);
        chk(idx, "bp_pc",     bp_pc,         v.e_addr);
        chk(idx, "bp_stall",  32'(bp_stall), 32'(v.e_bst));
        chk(idx, "id_valid",  32'(id_valid), 32'(v.e_val));
        if (v.e_val) begin
            chk(idx, "id_pc",    id_pc,         v.e_pc);
            chk(idx, "id_inst",  id_inst,       v.e_inst);
            chk(idx, "id_taken", 32'(id_taken), 32'(v.e_tk));
        end
    endtask

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    // Reset cycle: request low, stall high, PC at reset value, nothing valid
    function automatic vec_t rstv();
        return mk(1, 1,0,0, 0,0, 0,0, 0,1,  0,32'h0,1,0, 0,0,0);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        bp_next_pc = 0; bp_next_taken = 0; redirect = 0; redirect_pc = 0;
        stall = 0; id_ready = 0;

        //         rst gnt rv rdata      npc           tk rd rpc           st rdy  req addr          bst val pc            inst          tk
        // Streaming after reset: addresses 0,4,8; first instruction 2 cycles after grant
        add(rstv());
        add(mk(0, 1,0,0,         32'h4,   0, 0,0, 0,1,  1,32'h0,  0,0, 0,0,0));
        add(mk(0, 1,1,d(32'h0),  32'h8,   0, 0,0, 0,1,  1,32'h4,  0,0, 0,0,0));
        add(mk(0, 1,1,d(32'h4),  32'hC,   0, 0,0, 0,1,  1,32'h8,  0,1, 32'h0,d(32'h0),0));
        add(mk(0, 0,1,d(32'h8),  32'h10,  0, 0,0, 0,1,  1,32'hC,  1,1, 32'h4,d(32'h4),0));
        add(mk(0, 0,0,0,         32'h10,  0, 0,0, 0,1,  1,32'hC,  1,1, 32'h8,d(32'h8),0));
        add(mk(0, 0,0,0,         32'h10,  0, 0,0, 0,1,  1,32'hC,  1,0, 0,0,0));
        // Queue full with decode blocked: exactly four requests, head stays 0x0
        add(rstv());
        add(mk(0, 1,0,0,         32'h4,   0, 0,0, 0,0,  1,32'h0,  0,0, 0,0,0));
        add(mk(0, 1,1,d(32'h0),  32'h8,   0, 0,0, 0,0,  1,32'h4,  0,0, 0,0,0));
        add(mk(0, 1,1,d(32'h4),  32'hC,   0, 0,0, 0,0,  1,32'h8,  0,1, 32'h0,d(32'h0),0));
        add(mk(0, 1,1,d(32'h8),  32'h10,  0, 0,0, 0,0,  1,32'hC,  0,1, 32'h0,d(32'h0),0));
        add(mk(0, 1,1,d(32'hC),  32'h14,  0, 0,0, 0,0,  0,32'h10, 1,1, 32'h0,d(32'h0),0));
        add(mk(0, 1,0,0,         32'h14,  0, 0,0, 0,0,  0,32'h10, 1,1, 32'h0,d(32'h0),0));
        add(mk(0, 1,0,0,         32'h14,  0, 0,0, 0,1,  0,32'h10, 1,1, 32'h0,d(32'h0),0));
        add(mk(0, 0,0,0,         32'h14,  0, 0,0, 0,1,  1,32'h10, 1,1, 32'h4,d(32'h4),0));
        // Predicted-taken branch at 0x8 jumps to 0x100; its entry carries taken=1
        add(rstv());
        add(mk(0, 1,0,0,         32'h4,   0, 0,0, 0,1,  1,32'h0,  0,0, 0,0,0));
        add(mk(0, 1,1,d(32'h0),  32'h8,   0, 0,0, 0,1,  1,32'h4,  0,0, 0,0,0));
        add(mk(0, 1,1,d(32'h4),  32'h100, 1, 0,0, 0,1,  1,32'h8,  0,1, 32'h0,d(32'h0),0));
        add(mk(0, 1,1,d(32'h8),  32'h104, 0, 0,0, 0,1,  1,32'h100,0,1, 32'h4,d(32'h4),0));
        add(mk(0, 0,1,d(32'h100),32'h108, 0, 0,0, 0,1,  1,32'h104,1,1, 32'h8,d(32'h8),1));
        add(mk(0, 0,0,0,         32'h108, 0, 0,0, 0,1,  1,32'h104,1,1, 32'h100,d(32'h100),0));
        // Redirect with two requests outstanding: both late responses dropped
        add(rstv());
        add(mk(0, 1,0,0,         32'h4,   0, 0,0,       0,1,  1,32'h0,  0,0, 0,0,0));
        add(mk(0, 1,0,0,         32'h8,   0, 0,0,       0,1,  1,32'h4,  0,0, 0,0,0));
        add(mk(0, 1,0,0,         32'hC,   0, 1,32'h200, 0,1,  0,32'h8,  1,0, 0,0,0));
        add(mk(0, 1,1,d(32'h0),  32'h204, 0, 0,0,       0,1,  0,32'h200,1,0, 0,0,0));
        add(mk(0, 1,1,d(32'h4),  32'h204, 0, 0,0,       0,1,  0,32'h200,1,0, 0,0,0));
        add(mk(0, 1,0,0,         32'h204, 0, 0,0,       0,1,  1,32'h200,0,0, 0,0,0));
        add(mk(0, 0,1,d(32'h200),32'h208, 0, 0,0,       0,1,  1,32'h204,1,0, 0,0,0));
        add(mk(0, 0,0,0,         32'h208, 0, 0,0,       0,1,  1,32'h204,1,1, 32'h200,d(32'h200),0));
        // Redirect coinciding with a response and decode ready: one drop left
        add(rstv());
        add(mk(0, 1,0,0,         32'h4,   0, 0,0,       0,1,  1,32'h0,  0,0, 0,0,0));
        add(mk(0, 1,1,d(32'h0),  32'h8,   0, 0,0,       0,1,  1,32'h4,  0,0, 0,0,0));
        add(mk(0, 1,0,0,         32'hC,   0, 0,0,       0,0,  1,32'h8,  0,1, 32'h0,d(32'h0),0));
        add(mk(0, 1,1,d(32'h4),  32'h10,  0, 1,32'h300, 0,1,  0,32'hC,  1,0, 0,0,0));
        add(mk(0, 1,1,d(32'h8),  32'h304, 0, 0,0,       0,1,  0,32'h300,1,0, 0,0,0));
        add(mk(0, 1,0,0,         32'h304, 0, 0,0,       0,1,  1,32'h300,0,0, 0,0,0));
        add(mk(0, 0,1,d(32'h300),32'h308, 0, 0,0,       0,1,  1,32'h304,1,0, 0,0,0));
        add(mk(0, 0,0,0,         32'h308, 0, 0,0,       0,1,  1,32'h304,1,1, 32'h300,d(32'h300),0));
        // Stall for three cycles at PC 0x10 while queued entries drain
        add(rstv());
        add(mk(0, 1,0,0,         32'h4,   0, 0,0, 0,0,  1,32'h0,  0,0, 0,0,0));
        add(mk(0, 1,1,d(32'h0),  32'h8,   0, 0,0, 0,0,  1,32'h4,  0,0, 0,0,0));
        add(mk(0, 1,1,d(32'h4),  32'hC,   0, 0,0, 0,0,  1,32'h8,  0,1, 32'h0,d(32'h0),0));
        add(mk(0, 1,1,d(32'h8),  32'h10,  0, 0,0, 0,0,  1,32'hC,  0,1, 32'h0,d(32'h0),0));
        add(mk(0, 1,1,d(32'hC),  32'h14,  0, 0,0, 1,1,  0,32'h10, 1,1, 32'h0,d(32'h0),0));
        add(mk(0, 1,0,0,         32'h14,  0, 0,0, 1,1,  0,32'h10, 1,1, 32'h4,d(32'h4),0));
        add(mk(0, 1,0,0,         32'h14,  0, 0,0, 1,1,  0,32'h10, 1,1, 32'h8,d(32'h8),0));
        add(mk(0, 1,0,0,         32'h14,  0, 0,0, 0,1,  1,32'h10, 0,1, 32'hC,d(32'hC),0));
        add(mk(0, 0,0,0,         32'h18,  0, 0,0, 0,1,  1,32'h14, 1,0, 0,0,0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Back-to-back redirects: the second lands while one stale response
        // is being dropped, so one more drop remains before fetch resumes
        apply(rstv(), 100);
        apply(mk(0, 1,0,0,        32'h4, 0, 0,0,       0,1,  1,32'h0,  0,0, 0,0,0), 101);
        apply(mk(0, 1,0,0,        32'h8, 0, 0,0,       0,1,  1,32'h4,  0,0, 0,0,0), 102);
        apply(mk(0, 1,0,0,        32'hC, 0, 1,32'h400, 0,1,  0,32'h8,  1,0, 0,0,0), 103);
        apply(mk(0, 1,1,d(32'h0), 32'hC, 0, 1,32'h500, 0,1,  0,32'h400,1,0, 0,0,0), 104);
        apply(mk(0, 1,0,0,        32'hC, 0, 0,0,       0,1,  0,32'h500,1,0, 0,0,0), 105);
        apply(mk(0, 1,1,d(32'h4), 32'hC, 0, 0,0,       0,1,  0,32'h500,1,0, 0,0,0), 106);

        // Bounded wait for fetch to resume at the second redirect target
        begin
            int waited;
            waited = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                imem_gnt = 0; imem_rvalid = 0; redirect = 0; stall = 0;
                #1;
                if (imem_req) break;
                waited++;
            end
            chk(107, "resume_wait_cycles", 32'(waited), 32'd0);
            chk(108, "resume_addr", imem_addr, 32'h500);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
